// File: rtl/fetch_pkg.sv
// Shared widths, slot-order helper and queue-entry layout for the fetch-to-decode packer.
package fetch_pkg;

  localparam int FETCH_W = 4;
  localparam int PC_W    = 16;
  localparam int INST_W  = 16;

  // Slot 0 sits in the MSBs of every packed vector, so slot i maps to bit FETCH_W-1-i.
  function automatic int slot_bit(input int slot);
    return FETCH_W - 1 - slot;
  endfunction

  typedef struct packed {
    logic [FETCH_W*PC_W-1:0]   pc;
    logic [FETCH_W*INST_W-1:0] inst;
    logic [FETCH_W*PC_W-1:0]   recv;
    logic [FETCH_W-1:0]        pred;
    logic [FETCH_W-1:0]        slot_valid;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_pack_queue_if.sv
// Fetch-side and decode-side handshake bundle of the packet queue.
interface fetch_pack_queue_if #(parameter int DEPTH = 4);
  import fetch_pkg::*;

  logic                        flush;
  logic                        start;
  logic                        in_valid;
  logic                        in_ready;
  logic [PC_W-1:0]             pc;
  logic [FETCH_W*INST_W-1:0]   inst;
  logic [FETCH_W-1:0]          brnch_mask;
  logic [FETCH_W-1:0]          pred_taken;
  logic [FETCH_W*PC_W-1:0]     brnch_tgt;
  logic [FETCH_W-1:0]          is_im_jmp;
  logic                        out_valid;
  logic                        out_ready;
  logic [FETCH_W*PC_W-1:0]     pc_to_dec;
  logic [FETCH_W*INST_W-1:0]   inst_to_dec;
  logic [FETCH_W*PC_W-1:0]     recv_pc_to_dec;
  logic [FETCH_W-1:0]          pred_result_to_dec;
  logic [FETCH_W-1:0]          slot_valid_to_dec;
  logic [$clog2(DEPTH):0]      count;

  modport master (
    output flush, start, in_valid, pc, inst, brnch_mask, pred_taken, brnch_tgt, is_im_jmp,
           out_ready,
    input  in_ready, out_valid, pc_to_dec, inst_to_dec, recv_pc_to_dec, pred_result_to_dec,
           slot_valid_to_dec, count
  );

  modport slave (
    input  flush, start, in_valid, pc, inst, brnch_mask, pred_taken, brnch_tgt, is_im_jmp,
           out_ready,
    output in_ready, out_valid, pc_to_dec, inst_to_dec, recv_pc_to_dec, pred_result_to_dec,
           slot_valid_to_dec, count
  );
endinterface

// File: rtl/fetch_slot_pack.sv
// Combinational packing of one fetch slot: slot PC, instruction squash, recovery PC select.
module fetch_slot_pack
  import fetch_pkg::*;
#(
  parameter int SLOT = 0
) (
  input  logic [PC_W-1:0]   base_pc_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic              squash_i,
  input  logic              mask_i,
  input  logic              taken_i,
  input  logic [PC_W-1:0]   tgt_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   recv_o,
  output logic              pred_o
);

  assign pc_o   = base_pc_i + PC_W'(SLOT);
  assign inst_o = squash_i ? '0 : inst_i;
  assign pred_o = mask_i & taken_i;

  // Recovery PC is the path not predicted: fall-through for taken, target for not-taken.
  always_comb begin
    recv_o = '0;
    if (mask_i) recv_o = taken_i ? pc_o + PC_W'(1) : tgt_i;
  end

endmodule

// File: rtl/fetch_pack_queue.sv
// Packs a fetch group into a decode packet and buffers packets in a DEPTH-entry FIFO.
module fetch_pack_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  fetch_pack_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]   slot_pc   [FETCH_W];
  logic [INST_W-1:0] slot_inst [FETCH_W];
  logic [PC_W-1:0]   slot_recv [FETCH_W];
  logic              slot_pred [FETCH_W];

  for (genvar i = 0; i < FETCH_W; i++) begin : g_slot
    localparam int B = slot_bit(i);
    fetch_slot_pack #(.SLOT(i)) u_slot (
      .base_pc_i (bus.pc),
      .inst_i    (bus.inst[B*INST_W +: INST_W]),
      .squash_i  (bus.start | bus.is_im_jmp[B]),
      .mask_i    (bus.brnch_mask[B]),
      .taken_i   (bus.pred_taken[B]),
      .tgt_i     (bus.brnch_tgt[B*PC_W +: PC_W]),
      .pc_o      (slot_pc[i]),
      .inst_o    (slot_inst[i]),
      .recv_o    (slot_recv[i]),
      .pred_o    (slot_pred[i])
    );
  end

  fetch_entry_t entry_d;
  logic         taken_seen;

  // NOTE: blocking '=' here is deliberate; taken_seen must ripple slot to slot within one evaluation.
  always_comb begin
    entry_d    = '0;
    taken_seen = 1'b0;
    for (int i = 0; i < FETCH_W; i++) begin
      entry_d.pc[slot_bit(i)*PC_W +: PC_W]       = slot_pc[i];
      entry_d.inst[slot_bit(i)*INST_W +: INST_W] = slot_inst[i];
      entry_d.recv[slot_bit(i)*PC_W +: PC_W]     = slot_recv[i];
      entry_d.pred[slot_bit(i)]                  = slot_pred[i];
      entry_d.slot_valid[slot_bit(i)]            = !bus.start && !taken_seen;
      taken_seen                                 = taken_seen | slot_pred[i];
    end
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  fetch_entry_t     mem_q [DEPTH];

  assign bus.in_ready  = (count_q != CNT_W'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign push          = bus.in_valid & bus.in_ready & ~bus.flush;
  assign pop           = bus.out_valid & bus.out_ready & ~bus.flush;

  // NOTE: every next-state signal gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: payload storage has no reset; out_valid qualifies it, and a reset-free array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_d;
  end

  assign bus.pc_to_dec          = mem_q[rd_ptr_q].pc;
  assign bus.inst_to_dec        = mem_q[rd_ptr_q].inst;
  assign bus.recv_pc_to_dec     = mem_q[rd_ptr_q].recv;
  assign bus.pred_result_to_dec = mem_q[rd_ptr_q].pred;
  assign bus.slot_valid_to_dec  = mem_q[rd_ptr_q].slot_valid;
  assign bus.count              = count_q;

endmodule

// File: tb/tb_fetch_pack_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based packet model.
module tb_fetch_pack_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fetch_pack_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_pack_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference packet built straight from the slot rules, slot 0 first.
  function automatic fetch_entry_t model_pack(
    input logic [PC_W-1:0] pc, input logic [FETCH_W*INST_W-1:0] inst,
    input logic [FETCH_W-1:0] mask, input logic [FETCH_W-1:0] taken,
    input logic [FETCH_W*PC_W-1:0] tgt, input logic [FETCH_W-1:0] imj, input logic st);
    fetch_entry_t e;
    bit           dead;
    logic [PC_W-1:0] pci;
    int           b;
    e    = '0;
    dead = 0;
    for (int i = 0; i < FETCH_W; i++) begin
      b   = FETCH_W - 1 - i;
      pci = pc + PC_W'(i);
      e.pc[b*PC_W +: PC_W]       = pci;
      e.inst[b*INST_W +: INST_W] = (st || imj[b]) ? '0 : inst[b*INST_W +: INST_W];
      if (mask[b] && taken[b]) e.recv[b*PC_W +: PC_W] = pci + 1'b1;
      else if (mask[b])        e.recv[b*PC_W +: PC_W] = tgt[b*PC_W +: PC_W];
      e.pred[b]       = mask[b] && taken[b];
      e.slot_valid[b] = !st && !dead;
      if (mask[b] && taken[b]) dead = 1;
    end
    return e;
  endfunction

  fetch_entry_t exp_q[$];
  bit           m_push, m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst || bus.flush) begin
      exp_q.delete();
    end else begin
      m_pop  = exp_q.size() > 0 && bus.out_ready;
      m_push = bus.in_valid && exp_q.size() < DEPTH;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(model_pack(bus.pc, bus.inst, bus.brnch_mask, bus.pred_taken,
                                             bus.brnch_tgt, bus.is_im_jmp, bus.start));
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    check("in_ready", bus.in_ready, exp_q.size() != DEPTH);
    check("count", bus.count, exp_q.size());
    if (exp_q.size() != 0) begin
      check("pc_to_dec", bus.pc_to_dec, exp_q[0].pc);
      check("inst_to_dec", bus.inst_to_dec, exp_q[0].inst);
      check("recv_pc", bus.recv_pc_to_dec, exp_q[0].recv);
      check("pred_result", bus.pred_result_to_dec, exp_q[0].pred);
      check("slot_valid", bus.slot_valid_to_dec, exp_q[0].slot_valid);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic v, input logic rdy, input logic [PC_W-1:0] pc,
                       input logic [FETCH_W-1:0] mask, input logic [FETCH_W-1:0] taken,
                       input logic [FETCH_W-1:0] imj, input logic [FETCH_W*INST_W-1:0] inst,
                       input logic [FETCH_W*PC_W-1:0] tgt, input logic st, input logic fl);
    bus.in_valid   = v;
    bus.out_ready  = rdy;
    bus.pc         = pc;
    bus.brnch_mask = mask;
    bus.pred_taken = taken;
    bus.is_im_jmp  = imj;
    bus.inst       = inst;
    bus.brnch_tgt  = tgt;
    bus.start      = st;
    bus.flush      = fl;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, rdy, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [FETCH_W*INST_W-1:0] inst_pat;
    int exp_id;
    int guard;
    inst_pat = 64'h1111_2222_3333_4444;
    idle(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    compare_all();
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_in_ready", bus.in_ready, 1'b1);

    // Single push with a taken branch in slot 1, popped right away.
    drive(1'b1, 1'b1, 16'h0010, 4'b0100, 4'b0100, 4'b0000, inst_pat,
          64'h0000_0040_0000_0000, 1'b0, 1'b0);
    step();
    check("t1_pc", bus.pc_to_dec, 64'h0010_0011_0012_0013);
    check("t1_recv", bus.recv_pc_to_dec, 64'h0000_0012_0000_0000);
    check("t1_pred", bus.pred_result_to_dec, 4'b0100);
    check("t1_slot_valid", bus.slot_valid_to_dec, 4'b1100);
    idle(1'b1);
    step();
    check("t1_popped", bus.out_valid, 1'b0);

    // Two not-taken branches and an immediate jump in slot 2.
    drive(1'b1, 1'b0, 16'h0020, 4'b1001, 4'b0000, 4'b0010, inst_pat,
          64'h0100_0000_0000_0200, 1'b0, 1'b0);
    step();
    check("t2_recv", bus.recv_pc_to_dec, 64'h0100_0000_0000_0200);
    check("t2_inst_slot2", bus.inst_to_dec[16 +: 16], 16'h0000);
    check("t2_inst", bus.inst_to_dec, 64'h1111_2222_0000_4444);
    check("t2_slot_valid", bus.slot_valid_to_dec, 4'b1111);
    idle(1'b1);
    step();

    // Fill with packets 1..5 while decode stalls; packet 5 waits for space.
    for (int id = 1; id <= 5; id++) begin
      drive(1'b1, 1'b0, PC_W'(id << 8), '0, '0, '0, inst_pat, '0, 1'b0, 1'b0);
      step();
    end
    check("fill_in_ready", bus.in_ready, 1'b0);
    check("fill_count", bus.count, 3'd4);
    // Pop at full: push of packet 5 is refused this cycle.
    bus.out_ready = 1'b1;
    step();
    check("full_pushpop_count", bus.count, 3'd3);
    bus.out_ready = 1'b0;
    step();
    check("pkt5_accepted_count", bus.count, 3'd4);
    idle(1'b1);
    exp_id = 2;
    guard  = 0;
    while (bus.out_valid && guard < 10) begin
      check("drain_order", bus.pc_to_dec[FETCH_W*PC_W-1 -: PC_W], PC_W'(exp_id << 8));
      exp_id++;
      guard++;
      step();
    end
    check("drain_last_id", exp_id, 6);

    // Flush beats a same-cycle push.
    for (int id = 1; id <= 3; id++) begin
      drive(1'b1, 1'b0, PC_W'(16'h0A00 + id), '0, '0, '0, inst_pat, '0, 1'b0, 1'b0);
      step();
    end
    check("pre_flush_count", bus.count, 3'd3);
    drive(1'b1, 1'b1, 16'h0B00, '0, '0, '0, inst_pat, '0, 1'b0, 1'b1);
    step();
    check("flush_count", bus.count, 3'd0);
    check("flush_out_valid", bus.out_valid, 1'b0);
    drive(1'b1, 1'b0, 16'h0C00, '0, '0, '0, inst_pat, '0, 1'b0, 1'b0);
    step();
    check("post_flush_valid", bus.out_valid, 1'b1);
    idle(1'b1);
    step();

    // PC wrap with a taken branch in slot 1, then a boot-mode packet.
    drive(1'b1, 1'b0, 16'hFFFE, 4'b0100, 4'b0100, '0, inst_pat, '0, 1'b0, 1'b0);
    step();
    check("wrap_pc", bus.pc_to_dec, 64'hFFFE_FFFF_0000_0001);
    check("wrap_recv", bus.recv_pc_to_dec, 64'h0000_0000_0000_0000);
    drive(1'b1, 1'b0, 16'h0300, 4'b0100, 4'b0100, '0, inst_pat, '0, 1'b1, 1'b0);
    step();
    idle(1'b1);
    step();
    check("start_inst", bus.inst_to_dec, 64'h0);
    check("start_slot_valid", bus.slot_valid_to_dec, 4'b0000);
    drive(1'b1, 1'b0, 16'h0400, '0, '0, '0, inst_pat, '0, 1'b0, 1'b0);
    step();
    idle(1'b0);

    // Asynchronous reset mid-stall, observed before the next clock edge.
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", bus.out_valid, 1'b0);
    check("async_rst_in_ready", bus.in_ready, 1'b1);
    check("async_rst_count", bus.count, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    compare_all();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            PC_W'($urandom), FETCH_W'($urandom), FETCH_W'($urandom), FETCH_W'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 24) == 0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pack_queue.md
Name: fetch_pack_queue

Overview:
Parametrised fetch-to-decode packer and buffer. It builds a FETCH_W-wide decode packet from one fetch group: slot PCs, instructions with immediate jumps squashed, per-slot recovery PCs, prediction bits and a slot-valid mask. Packets are queued in a DEPTH-entry FIFO with valid/ready handshakes on both sides. It sits between the branch handler / predictor and the decoder, and absorbs decode stalls without re-fetching.

Parameters:
FETCH_W, 4, slots per fetch group (power of 2, 1..8)
DEPTH, 4, queue entries (power of 2, >=2)
PC_W, 16, PC width
INST_W, 16, instruction width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  mispredict/redirect; drops all queued packets
start  in  1  boot mode; accepted packets carry zero instructions
in_valid  in  1  fetch group present
in_ready  out  1  queue can accept (= !full)
pc  in  PC_W  PC of slot 0
inst  in  FETCH_W*INST_W  instructions; slot 0 in MSBs
brnch_mask  in  FETCH_W  slot holds a conditional branch; MSB = slot 0
pred_taken  in  FETCH_W  per-slot predicted direction (ignored where mask=0)
brnch_tgt  in  FETCH_W*PC_W  per-slot branch target
is_im_jmp  in  FETCH_W  slot is an immediate jump resolved in fetch
out_valid  out  1  head packet valid
out_ready  in  1  decoder accepts head
pc_to_dec  out  FETCH_W*PC_W  slot PCs
inst_to_dec  out  FETCH_W*INST_W  packed instructions
recv_pc_to_dec  out  FETCH_W*PC_W  per-slot recovery PC
pred_result_to_dec  out  FETCH_W  per-slot prediction bit
slot_valid_to_dec  out  FETCH_W  slots the decoder must issue
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst=1): rd/wr pointers=0, count=0, out_valid=0, in_ready=1. Payload outputs show the addressed entry; storage is not cleared, and decode must qualify it with out_valid.
- Packing is combinational on the inputs and is written into the queue on a push. For slot i:
  - pc_i = pc + i, mod 2^PC_W (wrap 0xFFFF -> 0x0000).
  - inst_i = 0 if start or is_im_jmp[i]; otherwise inst[i].
  - Branch slot (mask=1) with pred_taken=1: recv = pc_i + 1, pred_result = 1.
  - Branch slot with pred_taken=0: recv = brnch_tgt[i], pred_result = 0.
  - Non-branch slot: recv = 0, pred_result = 0.
  - slot_valid_i = 0 if start or if any earlier slot j<i has mask=1 and pred_taken=1; otherwise 1. Slots after the first predicted-taken branch are therefore dead. Any number of branches per group is legal.
- Push = in_valid & in_ready & !flush.
- Pop = out_valid & out_ready & !flush.
- in_ready = (count != DEPTH). It depends on registered count only, so a push into a full queue is refused even when a pop occurs in the same cycle.
- Simultaneous push and pop on a non-full queue: count is unchanged and both pointers advance.
- Latency: a packet pushed at edge N appears on the outputs after edge N (out_valid=1 in cycle N+1). There is no same-cycle bypass.
- Outputs are held stable while out_valid=1 and out_ready=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count saturates logically at DEPTH and never exceeds it. Empty means count=0; full means count=DEPTH.
- flush: at the next edge, pointers=0 and count=0. Flush overrides any same-cycle push or pop. out_valid=0 in the cycle after.
- rst asserted mid-operation: outputs go to reset state immediately, without waiting for a clock edge.
- start affects only packets pushed while it is high; already-queued packets are unaffected.

Decomposition:
- Shared package fetch_pkg: FETCH_W/PC_W/INST_W defaults, slot-index helper functions, and a packed struct for a queue entry (pc, inst, recv, pred, slot_valid), which sets the entry width.
- Sub-module fetch_slot_pack: combinational per-slot packing (PC add, squash, recovery select). Instantiated FETCH_W times in a generate loop; the slot_valid prefix-OR stays in the top level.
- FIFO storage and control: inline in fetch_pack_queue.

Test Plan:
- Reset then single push: pc=0x0010, mask=0100, pred_taken=0100, brnch_tgt slot1=0x0040, out_ready=1 → next cycle out_valid=1; pc_to_dec={0x0010,0x0011,0x0012,0x0013}; recv slot1=0x0012; pred_result=0100; slot_valid=1100; out_valid=0 after the pop.
- Not-taken and immediate jump: mask=1001, pred_taken=0000, targets 0x0100 (slot0) and 0x0200 (slot3), is_im_jmp=0010 → recv={0x0100,0,0,0x0200}; inst slot2=0; slot_valid=1111.
- Fill and stall: out_ready=0, push 5 packets back-to-back → in_ready=0 once count=4. The 5th packet is held until the first pop, and pop order matches push order 1..5.
- Push+pop at full: count=4, in_valid=1, out_ready=1 → the pop occurs, the push is refused (in_ready=0 that cycle), count=3.
- Flush priority: count=3, flush=1 together with in_valid=1 → next cycle count=0 and out_valid=0. The subsequent push appears with out_valid=1 one cycle later.
- Wrap and start: pc=0xFFFE → pc_to_dec={0xFFFE,0xFFFF,0x0000,0x0001}. Taken branch at slot1 → recv=0x0000. start=1 → inst_to_dec=0, slot_valid=0000. rst pulsed asynchronously mid-stall → out_valid drops without a clock edge.
